// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for one shared 64-bit ripple adder.
// Operands are held for SETTLE_CYCLES before the result is captured.

module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        overflow,
    output logic        carryout
);

    logic c;

    always_comb begin
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

    assign carryout = c;
    assign overflow = (a[63] == b[63]) & (sum[63] != a[63]);

endmodule

module adder_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_overflow,
    output logic        rsp_carryout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_e;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] op_a_q, op_a_d;
    logic [63:0] op_b_q, op_b_d;
    logic        id_q, id_d;
    logic        rv_q, rv_d;
    logic [63:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        co_q, co_d;

    logic        gnt0, gnt1, idle;
    logic [63:0] add_sum;
    logic        add_ovf, add_co;

    adder64 u_add (
        .a        (op_a_q),
        .b        (op_b_q),
        .sum      (add_sum),
        .overflow (add_ovf),
        .carryout (add_co)
    );

    // prio_q == 0 favours requester 0 when both are valid
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | ~prio_q);
        gnt1 = req1_valid & (~req0_valid | prio_q);
    end

    assign idle       = (state_q == IDLE);
    assign req0_ready = reset_n & idle & gnt0;
    assign req1_ready = reset_n & idle & gnt1;
    assign busy       = ~idle;

    assign rsp_valid    = rv_q;
    assign rsp_id       = id_q;
    assign rsp_sum      = sum_q;
    assign rsp_overflow = ovf_q;
    assign rsp_carryout = co_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        id_d    = id_q;
        rv_d    = rv_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        co_d    = co_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    op_a_d  = gnt1 ? req1_a : req0_a;
                    op_b_d  = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    prio_d  = ~gnt1;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    sum_d   = add_sum;
                    ovf_d   = add_ovf;
                    co_d    = add_co;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 8'd0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            id_q    <= 1'b0;
            rv_q    <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            co_q    <= co_d;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level reference model.

module tb_adder_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_sum;
    logic        rsp_overflow, rsp_carryout, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow),
        .rsp_carryout (rsp_carryout),
        .busy         (busy)
    );

    typedef struct {
        bit          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sum;
        bit          ovf;
        bit          co;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req1_a = '0;
        req1_b = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    function automatic void ref_add(input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] s, output bit o,
                                    output bit c);
        logic [64:0] u;
        logic signed [64:0] w;
        u = {1'b0, a} + {1'b0, b};
        w = $signed({a[63], a}) + $signed({b[63], b});
        s = u[63:0];
        c = u[64];
        o = (w[64] != w[63]);
    endfunction

    task automatic do_op(input vec_t v);
        int c;
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1;
            req1_a = v.a;
            req1_b = v.b;
        end else begin
            req0_valid = 1'b1;
            req0_a = v.a;
            req0_b = v.b;
        end
        #1;
        chk("op_ready", 64'(v.id ? req1_ready : req0_ready), 64'd1);
        chk("op_other_ready", 64'(v.id ? req0_ready : req1_ready), 64'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = {$urandom, $urandom};
        req0_b = {$urandom, $urandom};
        req1_a = {$urandom, $urandom};
        req1_b = {$urandom, $urandom};
        c = 0;
        while (!rsp_valid && c < 20) begin
            step();
            c++;
        end
        chk("op_latency", 64'(c), 64'(S));
        chk("op_sum", rsp_sum, v.sum);
        chk("op_ovf", 64'(rsp_overflow), 64'(v.ovf));
        chk("op_co", 64'(rsp_carryout), 64'(v.co));
        chk("op_id", 64'(rsp_id), 64'(v.id));
        step();
        chk("op_rsp_clear", 64'(rsp_valid), 64'd0);
        chk("op_idle", 64'(busy), 64'd0);
        rsp_ready = 1'b0;
    endtask

    // reference model state for the random phase
    bit          m_rv, m_id, m_prio, p_id, m_ovf, m_co, p_ovf, p_co;
    logic [63:0] m_sum, p_sum;
    int          m_left;

    function automatic logic [63:0] pick_operand();
        logic [63:0] x;
        case ($urandom_range(0, 5))
            0: x = 64'hFFFF_FFFF_FFFF_FFFF;
            1: x = 64'h8000_0000_0000_0000;
            2: x = 64'h7FFF_FFFF_FFFF_FFFF;
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    initial begin
        int c;
        int g[$];
        int acc[$];
        bit idle, e0, e1;

        tbl[0] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                   64'h8000_0000_0000_0000, 1, 0};
        tbl[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1};
        tbl[2] = '{0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h7FFF_FFFF_FFFF_FFFF, 1, 1};
        tbl[3] = '{1, 64'h0, 64'h0, 64'h0, 0, 0};
        tbl[4] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                   64'h2222_2222_2222_2211, 0, 0};
        tbl[5] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                   64'h0, 1, 1};
        tbl[6] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFE, 0, 1};

        // reset state with both requesters asserting valid
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_sum", rsp_sum, 64'd0);
        chk("rst_rsp_flags",
            64'({rsp_id, rsp_overflow, rsp_carryout}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        step();

        foreach (tbl[i]) do_op(tbl[i]);

        // reset pulsed mid-operation; last table op left prio on req1
        req0_valid = 1'b1;
        req0_a = 64'h5;
        req0_b = 64'h6;
        rsp_ready = 1'b1;
        #1;
        chk("rs_ready", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        chk("rs_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rs_busy_low", 64'(busy), 64'd0);
        chk("rs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rs_rsp_sum", rsp_sum, 64'd0);
        chk("rs_ready_low", 64'({req0_ready, req1_ready}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rs_grant0", 64'(req0_ready), 64'd1);
        chk("rs_grant1", 64'(req1_ready), 64'd0);
        step();
        idle_inputs();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rsp_ready = 1'b0;

        // response stalled for five cycles with both requesters waiting
        req1_valid = 1'b1;
        req1_a = 64'hFFFF_FFFF_FFFF_FFFF;
        req1_b = 64'h1;
        #1;
        chk("st_ready1", 64'(req1_ready), 64'd1);
        step();
        req0_valid = 1'b1;
        req1_a = 64'h3;
        c = 0;
        while (!rsp_valid && c < 20) begin
            step();
            c++;
        end
        chk("st_latency", 64'(c), 64'(S));
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", 64'(rsp_valid), 64'd1);
            chk("st_sum", rsp_sum, 64'd0);
            chk("st_flags",
                64'({rsp_id, rsp_overflow, rsp_carryout}), 64'b101);
            chk("st_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("st_hs_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
        step();
        chk("st_rsp_clear", 64'(rsp_valid), 64'd0);
        chk("st_idle", 64'(busy), 64'd0);
        idle_inputs();
        do_reset();

        // both valid continuously: grants alternate
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 64'h10;
        req1_a = 64'h20;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("rr_one_ready", 64'(req0_ready & req1_ready), 64'd0);
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            step();
        end
        chk("rr_count", 64'(g.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < g.size(); i++)
            chk("rr_grant", 64'(g[i]), 64'(i % 2));
        idle_inputs();
        do_reset();

        // lone requester served back-to-back
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (req0_ready) acc.push_back(i);
            if (rsp_valid) chk("lone_id", 64'(rsp_id), 64'd0);
            chk("lone_ready1", 64'(req1_ready), 64'd0);
            step();
        end
        chk("lone_count", 64'(acc.size() >= 3), 64'd1);
        for (int i = 0; i < 3 && i < acc.size(); i++)
            chk("lone_accept_cycle", 64'(acc[i]), 64'(i * (S + 2)));
        idle_inputs();
        do_reset();

        // random traffic against the reference model
        m_rv = 0;
        m_prio = 0;
        m_left = 0;
        for (int i = 0; i < 600; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = pick_operand();
            req0_b = pick_operand();
            req1_a = pick_operand();
            req1_b = pick_operand();
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            idle = !m_rv && m_left == 0;
            e0 = idle && req0_valid && (!req1_valid || !m_prio);
            e1 = idle && req1_valid && (!req0_valid || m_prio);
            chk("rnd_ready", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
            chk("rnd_busy", 64'(busy), 64'(!idle));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("rnd_sum", rsp_sum, m_sum);
                chk("rnd_flags",
                    64'({rsp_id, rsp_overflow, rsp_carryout}),
                    64'({m_id, m_ovf, m_co}));
            end
            if (e0 || e1) begin
                p_id = e1;
                ref_add(e1 ? req1_a : req0_a, e1 ? req1_b : req0_b,
                        p_sum, p_ovf, p_co);
                m_prio = !e1;
                m_left = S;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_rv = 1;
                    m_sum = p_sum;
                    m_ovf = p_ovf;
                    m_co = p_co;
                    m_id = p_id;
                end
            end else if (m_rv && rsp_ready) begin
                m_rv = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of clk cycles operands are held on the shared 64-bit ripple adder before results are captured (legal range 1-255).
REQ-002 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  64  operands of requester 0/1.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  arbiter accepts requester 0/1 this cycle.
REQ-007 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; response handshake.
REQ-008 SHALL have ports rsp_id  output  1  requester of current response; rsp_sum  output  64  A+B mod 2^64; rsp_overflow  output  1  signed overflow; rsp_carryout  output  1  unsigned carry.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL instantiate exactly one team 64-bit adder (carry-in 0, outputs sum/overflow/carryout), driven only from internal operand registers op_a/op_b.
REQ-011 SHALL implement FSM states IDLE, SETTLE, DONE.
REQ-012 SHALL, in IDLE, compute grant: only one valid -> that one; both valid -> requester named by round-robin pointer prio; neither -> no grant.
REQ-013 SHALL assert reqN_ready only in IDLE and only for the granted requester; never both ready in one cycle; ready SHALL NOT depend on rsp_ready.
REQ-014 SHALL, on the edge where granted valid & ready, load op_a/op_b from that requester, record its id, set prio to the other requester, load counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-015 SHALL update prio only on an accepted transfer; a lone requester SHALL be served back-to-back without waiting on the idle one.
REQ-016 SHALL, in SETTLE, decrement counter each cycle; on the edge where counter == 0, capture adder sum/overflow/carryout into rsp_sum/rsp_overflow/rsp_carryout, set rsp_valid, go to DONE.
REQ-017 SHALL give latency: transfer at edge k -> rsp_valid high after edge k+SETTLE_CYCLES.
REQ-018 SHALL hold rsp_valid, rsp_id, rsp_sum, rsp_overflow, rsp_carryout stable in DONE until rsp_valid & rsp_ready.
REQ-019 SHALL, on the response-handshake edge, clear rsp_valid and return to IDLE; no new request accepted on that same edge (minimum issue interval SETTLE_CYCLES+2 cycles).
REQ-020 SHALL hold op_a/op_b constant throughout SETTLE and DONE regardless of requester inputs.
REQ-021 SHALL compute overflow as (A[63] == B[63]) & (sum[63] != A[63]) and carryout as bit 64 of the unsigned sum, as produced by the adder.
REQ-022 SHALL ignore reqN_valid deasserted before acceptance (no grant latching across cycles).

Reset
REQ-023 SHALL, while reset_n low, asynchronously force: state IDLE, prio 0, counter 0, op_a/op_b 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_overflow 0, rsp_carryout 0.
REQ-024 SHALL keep req0_ready, req1_ready, busy low while reset_n low.
REQ-025 SHALL, on reset asserted in SETTLE or DONE, abandon the operation with no response issued; first grant after release SHALL follow REQ-012 with prio 0.

Verification (SETTLE_CYCLES = 2)
REQ-026 SHALL cover: req0 only, A=7FFF_FFFF_FFFF_FFFF, B=1, rsp_ready=1 -> rsp_valid 2 cycles after transfer, rsp_sum=8000_0000_0000_0000, overflow=1, carryout=0, rsp_id=0.
REQ-027 SHALL cover: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 over four operations; ready never high for both.
REQ-028 SHALL cover: req1 A=FFFF_FFFF_FFFF_FFFF, B=1, rsp_ready=0 for 5 cycles -> rsp_valid held, sum=0, carryout=1, overflow=0, no ready asserted until handshake, IDLE one cycle after.
REQ-029 SHALL cover: A=8000_0000_0000_0000, B=FFFF_FFFF_FFFF_FFFF -> sum=7FFF_FFFF_FFFF_FFFF, overflow=1, carryout=1; requester inputs changed during SETTLE do not alter result.
REQ-030 SHALL cover: reset_n pulsed low during SETTLE -> all outputs at reset values immediately, no response; next request with both valid granted to req0.
REQ-031 SHALL cover: req0 valid alone for three operations -> each accepted in the first IDLE cycle, rsp_id=0 every time.
